// File: rtl/ifetch_queue.sv
// ---------------------------------------------------------------------------
// ifetch_queue
//
// Instruction fetch front end. It walks the PC stream and issues word fetches
// over a valid/ready request channel. It takes in-order responses into a
// small queue and hands each word to decode together with its PC. A redirect
// flushes the queue. Any responses still in flight at that point are counted
// as stale and dropped when they arrive.
//
// Parameters:
//   RESET_ADDR  first fetch address after reset
//   QDEPTH      queue entries (power of two, 2..16); also caps requests
//               in flight
//
// Ports:
//   clk            clock, all state changes on the rising edge
//   R              synchronous active-high reset
//   redir_valid    redirect the fetch stream this cycle
//   redir_addr     new fetch address
//   mem_req_valid  fetch request to instruction memory
//   mem_req_ready  memory accepts the request
//   mem_addr       word address of the request
//   mem_rsp_valid  response beat (in order, no backpressure)
//   mem_rsp_data   instruction word of the response
//   inst_valid     queue head valid
//   inst_ready     decode consumes the head
//   inst_data      head instruction word
//   inst_pc        head PC
//   fetch_err      misaligned redirect trap
//
// Optional feature, macro IFETCH_ALIGN_CHK_EN:
//   defined   - a misaligned redirect parks the fetcher in ERR with fetch_err
//               set until an aligned redirect arrives
//   undefined - redirect targets are forced word aligned and fetch_err is 0
// ---------------------------------------------------------------------------
module ifetch_queue #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          QDEPTH     = 4
) (
  input  logic        clk,
  input  logic        R,
  input  logic        redir_valid,
  input  logic [31:0] redir_addr,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        fetch_err
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW+1:0] OCC_LIMIT = (CW+2)'(QDEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1
`ifdef IFETCH_ALIGN_CHK_EN
    ,
    ERR   = 2'd2
`endif
  } state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] live;
  logic [CW-1:0] stale;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [31:0]   q_data [QDEPTH];
  logic [31:0]   q_pc   [QDEPTH];

  logic [CW+1:0] occupancy;
  logic          req_fire;
  logic          rsp_live;
  logic          rsp_stale;
  logic          push;
  logic          pop;
  logic [31:0]   redir_target;

  // Every queued entry and every outstanding request (live or stale) holds a
  // credit. A new request goes out only while a credit is free, so a
  // response can always be pushed. A redirect cycle never issues, which
  // keeps the old and the new stream from mixing in the same beat.
  assign occupancy     = (CW+2)'(count) + (CW+2)'(live) + (CW+2)'(stale);
  assign mem_req_valid = (state == FETCH) && !redir_valid && (occupancy < OCC_LIMIT);
  assign mem_addr      = fetch_pc;
  assign req_fire      = mem_req_valid && mem_req_ready;

  // Responses come back in order. So while any stale requests are
  // outstanding, the next beat belongs to the flushed stream.
  assign rsp_stale = mem_rsp_valid && (stale != '0);
  assign rsp_live  = mem_rsp_valid && (stale == '0);

  // A redirect wins over both push and pop. The queue is being emptied anyway.
  assign push = rsp_live && !redir_valid;
  assign pop  = inst_valid && inst_ready && !redir_valid;

  // The head is visible straight from the storage array. An empty queue
  // shows zero data and the PC the next live response will carry.
  assign inst_valid = (count != '0);
  assign inst_data  = inst_valid ? q_data[head] : '0;
  assign inst_pc    = inst_valid ? q_pc[head] : rsp_pc;

`ifdef IFETCH_ALIGN_CHK_EN
  logic redir_bad;

  // Keep the raw target. A misaligned one is never fetched because the FSM
  // parks in ERR until an aligned redirect replaces it.
  assign redir_bad    = (redir_addr[1:0] != 2'b00);
  assign redir_target = redir_addr;
`else
  // Without the alignment trap, the low address bits are simply dropped.
  assign redir_target = redir_addr & 32'hFFFF_FFFC;
`endif

  // Control FSM. IDLE holds the fetcher for one cycle after reset. In FETCH
  // the fetcher streams requests. ERR, when built, blocks issue after a
  // misaligned redirect, and fetch_err is registered so it rises on the
  // cycle after the bad redirect.
  always_ff @(posedge clk) begin
    if (R) begin
      state <= IDLE;
`ifdef IFETCH_ALIGN_CHK_EN
      fetch_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: state <= FETCH;
`ifdef IFETCH_ALIGN_CHK_EN
        FETCH: begin
          if (redir_valid && redir_bad) begin
            state     <= ERR;
            fetch_err <= 1'b1;
          end
        end
        ERR: begin
          if (redir_valid && !redir_bad) begin
            state     <= FETCH;
            fetch_err <= 1'b0;
          end
        end
`else
        FETCH: state <= FETCH;
`endif
        default: state <= IDLE;
      endcase
    end
  end

`ifndef IFETCH_ALIGN_CHK_EN
  assign fetch_err = 1'b0;
`endif

  // PC tracking, queue pointers and the three credit counters. On a
  // redirect, everything still outstanding becomes stale. A beat arriving
  // in that same cycle is one of those requests and is dropped right away,
  // so it is taken off the stale total straight away.
  always_ff @(posedge clk) begin
    if (R) begin
      fetch_pc <= RESET_ADDR;
      rsp_pc   <= RESET_ADDR;
      count    <= '0;
      live     <= '0;
      stale    <= '0;
      head     <= '0;
      tail     <= '0;
    end else if (redir_valid) begin
      fetch_pc <= redir_target;
      rsp_pc   <= redir_target;
      count    <= '0;
      live     <= '0;
      stale    <= stale + live - CW'(mem_rsp_valid);
      head     <= '0;
      tail     <= '0;
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (push) begin
        rsp_pc <= rsp_pc + 32'd4;
        tail   <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
      live  <= live + CW'(req_fire) - CW'(rsp_live);
      if (rsp_stale) begin
        stale <= stale - 1'b1;
      end
    end
  end

  // Queue storage needs no reset. Whether an entry is valid is decided only
  // by count and the pointers.
  always_ff @(posedge clk) begin
    if (!R && push) begin
      q_data[tail] <= mem_rsp_data;
      q_pc[tail]   <= rsp_pc;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// ---------------------------------------------------------------------------
// tb_ifetch_queue
//
// Self-checking bench for ifetch_queue. An instruction memory model replies
// in order after a random latency, with data derived from the requested
// address. A transaction-level reference model keeps the expected decode
// queue and the list of outstanding fetches, and every cycle's outputs are
// compared against it. Directed phases pin the timing and boundary cases to
// hand-computed constants. A long random phase then mixes stalls, redirects
// and resets.
// ---------------------------------------------------------------------------
module tb_ifetch_queue;

  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
  localparam int          QDEPTH     = 4;

  logic        clk = 1'b0;
  logic        R;
  logic        redir_valid;
  logic [31:0] redir_addr;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        fetch_err;

  ifetch_queue #(.RESET_ADDR(RESET_ADDR), .QDEPTH(QDEPTH)) dut (
    .clk          (clk),
    .R            (R),
    .redir_valid  (redir_valid),
    .redir_addr   (redir_addr),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_addr     (mem_addr),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .inst_data    (inst_data),
    .inst_pc      (inst_pc),
    .fetch_err    (fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; bit stale; } flight_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } entry_t;
  typedef struct { logic [31:0] addr; int due; } memreq_t;

  // Reference model: expected decode queue, outstanding fetches, next PC
  flight_t     inflight[$];
  entry_t      expq[$];
  logic [31:0] m_pc;
  int          m_state;
  bit          m_err;

  // Instruction memory model, fed by the handshakes the DUT actually makes
  memreq_t     memq[$];

  // Per-cycle stimulus controls
  bit          c_reset, c_redir, c_iready, c_mready;
  logic [31:0] c_raddr;
  int          c_lat_min, c_lat_max;
  int          lit_mode;

  // Values captured from the current cycle
  bit          s_rsp, s_dhs, s_ival;
  logic [31:0] s_daddr;

  // Records of what the DUT did, used for the literal checks
  logic [31:0] d_pop_pc[$];
  logic [31:0] d_pop_cyc[$];
  logic [31:0] d_hs_cyc[$];
  logic [31:0] d_hs_addr[$];
  int          dhs_count;

  int cyc, rel_cyc, redir_cyc;
  int tests, fails;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, want);
    end
  endtask

  task automatic clearRecords();
    d_pop_pc.delete();
    d_pop_cyc.delete();
    d_hs_cyc.delete();
    d_hs_addr.delete();
    dhs_count = 0;
  endtask

  // Drive the DUT inputs for this cycle. Memory replies when the oldest
  // request has reached its due cycle.
  task automatic applyStimulus();
    R             = c_reset;
    redir_valid   = c_redir;
    redir_addr    = c_raddr;
    inst_ready    = c_iready;
    mem_req_ready = c_mready;
    if (!c_reset && memq.size() > 0 && memq[0].due <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = memword(memq[0].addr);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = $urandom;
    end
  endtask

  // Compare all outputs with the model, plus any literal expectations the
  // current directed phase has armed.
  task automatic checkOutput();
    bit exp_req;
    exp_req = (m_state == 1) && !c_redir && ((expq.size() + inflight.size()) < QDEPTH);
    check("mem_req_valid", 32'(mem_req_valid), 32'(exp_req));
    if (exp_req) check("mem_addr", mem_addr, m_pc);
    check("inst_valid", 32'(inst_valid), 32'(expq.size() > 0));
    if (expq.size() > 0) begin
      check("inst_pc", inst_pc, expq[0].pc);
      check("inst_data", inst_data, expq[0].data);
    end
    check("fetch_err", 32'(fetch_err), 32'(m_err));
    case (lit_mode)
      1: begin
        check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_fetch_err", 32'(fetch_err), 32'd0);
        check("rst_mem_addr", mem_addr, RESET_ADDR);
        check("rst_inst_pc", inst_pc, RESET_ADDR);
        check("rst_inst_data", inst_data, 32'd0);
      end
      2: check("flush_inst_valid", 32'(inst_valid), 32'd0);
      3: begin
        check("err_fetch_err", 32'(fetch_err), 32'd1);
        check("err_no_request", 32'(mem_req_valid), 32'd0);
      end
      4: check("resume_fetch_err", 32'(fetch_err), 32'd0);
      default: ;
    endcase
  endtask

  // Advance the model by one clock edge using this cycle's inputs.
  task automatic updateModel();
    entry_t  e;
    flight_t f;
    memreq_t mr;
    bit      do_pop, mhs;
    int      occ;
    if (c_reset) begin
      expq.delete();
      inflight.delete();
      memq.delete();
      m_state = 0;
      m_pc    = RESET_ADDR;
      m_err   = 1'b0;
      return;
    end
    occ    = expq.size() + inflight.size();
    do_pop = !c_redir && c_iready && (expq.size() > 0);
    mhs    = (m_state == 1) && !c_redir && (occ < QDEPTH) && c_mready;
    if (s_rsp) begin
      tests++;
      assert (inflight.size() > 0) else begin
        fails++;
        $display("[TB] FAIL rsp_protocol at cycle %0d: response with nothing in flight", cyc);
      end
      if (inflight.size() > 0) begin
        f = inflight.pop_front();
        if (!f.stale && !c_redir) begin
          e.pc   = f.pc;
          e.data = memword(f.pc);
          expq.push_back(e);
        end
      end
    end
    if (do_pop) void'(expq.pop_front());
    if (mhs) begin
      f.pc    = m_pc;
      f.stale = 1'b0;
      inflight.push_back(f);
      m_pc = m_pc + 32'd4;
    end
    if (c_redir) begin
      foreach (inflight[i]) inflight[i].stale = 1'b1;
      expq.delete();
`ifdef IFETCH_ALIGN_CHK_EN
      m_pc = c_raddr;
      if (m_state == 0) m_state = 1;
      else if (c_raddr[1:0] != 2'b00) begin m_state = 2; m_err = 1'b1; end
      else begin m_state = 1; m_err = 1'b0; end
`else
      m_pc = {c_raddr[31:2], 2'b00};
      m_state = 1;
`endif
    end else if (m_state == 0) begin
      m_state = 1;
    end
    if (s_rsp) void'(memq.pop_front());
    if (s_dhs) begin
      mr.addr = s_daddr;
      mr.due  = cyc + int'($urandom_range(c_lat_max, c_lat_min));
      memq.push_back(mr);
    end
  endtask

  task automatic stepCycle();
    @(negedge clk);
    applyStimulus();
    #1;
    checkOutput();
    s_rsp   = mem_rsp_valid;
    s_dhs   = mem_req_valid && mem_req_ready && !c_reset;
    s_daddr = mem_addr;
    s_ival  = inst_valid;
    if (s_dhs) begin
      dhs_count++;
      d_hs_cyc.push_back(32'(cyc));
      d_hs_addr.push_back(mem_addr);
    end
    if (!c_reset && !c_redir && inst_valid && inst_ready) begin
      d_pop_pc.push_back(inst_pc);
      d_pop_cyc.push_back(32'(cyc));
    end
    @(posedge clk);
    updateModel();
    cyc++;
  endtask

  task automatic doReset();
    c_reset = 1'b1;
    c_redir = 1'b0;
    stepCycle();
    lit_mode = 1;
    stepCycle();
    lit_mode = 0;
    c_reset = 1'b0;
    clearRecords();
    rel_cyc = cyc;
  endtask

  task automatic redirectTo(input logic [31:0] a);
    c_redir = 1'b1;
    c_raddr = a;
    redir_cyc = cyc;
    stepCycle();
    c_redir = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0; lit_mode = 0;
    c_reset = 1'b1; c_redir = 1'b0; c_raddr = '0;
    c_iready = 1'b1; c_mready = 1'b1; c_lat_min = 1; c_lat_max = 1;
    m_state = 0; m_pc = RESET_ADDR; m_err = 1'b0;
    applyStimulus();

    // Streaming with single-cycle memory and decode always ready
    doReset();
    repeat (12) stepCycle();
    check("first_req_cycle", qat(d_hs_cyc, 0), 32'(rel_cyc + 1));
    check("first_pop_cycle", qat(d_pop_cyc, 0), 32'(rel_cyc + 3));
    check("stream_pc0", qat(d_pop_pc, 0), 32'h0);
    check("stream_pc1", qat(d_pop_pc, 1), 32'h4);
    check("stream_pc2", qat(d_pop_pc, 2), 32'h8);
    check("stream_pc3", qat(d_pop_pc, 3), 32'hC);
    check("stream_pc4", qat(d_pop_pc, 4), 32'h10);
    check("stream_rate", qat(d_pop_cyc, 4), 32'(rel_cyc + 7));

    // Decode stalled: the credit limit stops issue at QDEPTH requests
    doReset();
    c_iready = 1'b0;
    repeat (20) stepCycle();
    check("stall_req_count", 32'(dhs_count), 32'd4);
    c_iready = 1'b1;
    repeat (8) stepCycle();
    check("drain_pc0", qat(d_pop_pc, 0), 32'h0);
    check("drain_pc1", qat(d_pop_pc, 1), 32'h4);
    check("drain_pc2", qat(d_pop_pc, 2), 32'h8);
    check("drain_pc3", qat(d_pop_pc, 3), 32'hC);

    // Latency 3, redirect with three requests outstanding
    doReset();
    c_lat_min = 3; c_lat_max = 3;
    for (int i = 0; i < 20 && dhs_count < 3; i++) stepCycle();
    check("three_in_flight", 32'(dhs_count), 32'd3);
    redirectTo(32'h100);
    repeat (15) stepCycle();
    check("redir_first_pc", qat(d_pop_pc, 0), 32'h100);
    check("redir_first_cycle", qat(d_pop_cyc, 0), 32'(redir_cyc + 5));

    // Redirect coinciding with a response and a pop
    doReset();
    c_lat_min = 1; c_lat_max = 1;
    repeat (8) stepCycle();
    redirectTo(32'h300);
    check("redir_saw_rsp", 32'(s_rsp), 32'd1);
    check("redir_saw_head", 32'(s_ival), 32'd1);
    clearRecords();
    lit_mode = 2;
    stepCycle();
    lit_mode = 0;
    repeat (6) stepCycle();
    check("after_flush_pc", qat(d_pop_pc, 0), 32'h300);

    // Misaligned redirect
    doReset();
    repeat (6) stepCycle();
`ifdef IFETCH_ALIGN_CHK_EN
    redirectTo(32'h102);
    lit_mode = 3;
    repeat (4) stepCycle();
    lit_mode = 0;
    redirectTo(32'h200);
    clearRecords();
    lit_mode = 4;
    stepCycle();
    lit_mode = 0;
    repeat (4) stepCycle();
    check("resume_addr", qat(d_hs_addr, 0), 32'h200);
`else
    redirectTo(32'h102);
    clearRecords();
    repeat (4) stepCycle();
    check("align_addr", qat(d_hs_addr, 0), 32'h100);
`endif

    // Address wrap, then reset in the middle of the stream
    doReset();
    repeat (4) stepCycle();
    redirectTo(32'hFFFF_FFF8);
    clearRecords();
    repeat (10) stepCycle();
    check("wrap_pc0", qat(d_pop_pc, 0), 32'hFFFF_FFF8);
    check("wrap_pc1", qat(d_pop_pc, 1), 32'hFFFF_FFFC);
    check("wrap_pc2", qat(d_pop_pc, 2), 32'h0000_0000);
    check("wrap_pc3", qat(d_pop_pc, 3), 32'h0000_0004);
    doReset();

    // Random traffic against the reference model
    c_lat_min = 1; c_lat_max = 4;
    for (int n = 0; n < 4000; n++) begin
      logic [31:0] r;
      r        = $urandom;
      c_mready = ($urandom_range(3, 0) != 0);
      c_iready = ($urandom_range(2, 0) != 0);
      c_reset  = ($urandom_range(399, 0) == 0);
      c_redir  = (m_state != 0) && ($urandom_range(19, 0) == 0);
      case ($urandom_range(3, 0))
        0:       c_raddr = r;
        1:       c_raddr = 32'hFFFF_FFF0 | (r & 32'h0000_000C);
        default: c_raddr = r & 32'hFFFF_FFFC;
      endcase
      stepCycle();
    end
    c_reset = 1'b0;
    c_redir = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
